// File: rtl/prog_timer.sv
// ============================================================================
// Module  : prog_timer
// Purpose : Programmable tick timer with prescaler, one-shot/auto-reload,
//           pause, abort and restart.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_timer #(
    parameter int pCOUNT_BITS    = 8,
    parameter int pPRESCALE_BITS = 4
) (
    input  logic                      i_clock,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic                      i_pause,
    input  logic                      i_auto_reload,
    input  logic [pCOUNT_BITS-1:0]    i_ticks,
    input  logic [pPRESCALE_BITS-1:0] i_prescale,
    output logic                      o_busy,
    output logic                      o_paused,
    output logic                      o_done,
    output logic                      o_expired,
    output logic [pCOUNT_BITS-1:0]    o_remaining
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [pCOUNT_BITS-1:0]    c_REM_ONE = pCOUNT_BITS'(1);
    localparam logic [pPRESCALE_BITS-1:0] c_PSC_ONE = pPRESCALE_BITS'(1);

    state_t                    state_q,     state_d;
    logic [pCOUNT_BITS-1:0]    remaining_q, remaining_d;
    logic [pCOUNT_BITS-1:0]    ticks_q,     ticks_d;
    logic [pPRESCALE_BITS-1:0] prescale_q,  prescale_d;
    logic [pPRESCALE_BITS-1:0] psc_cnt_q,   psc_cnt_d;
    logic                      auto_q,      auto_d;
    logic                      done_q,      done_d;

    logic w_active;
    logic w_tick;

    assign w_active = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign w_tick   = (psc_cnt_q == prescale_q);

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            ticks_q     <= '0;
            prescale_q  <= '0;
            psc_cnt_q   <= '0;
            auto_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ticks_q     <= ticks_d;
            prescale_q  <= prescale_d;
            psc_cnt_q   <= psc_cnt_d;
            auto_q      <= auto_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ticks_d     = ticks_q;
        prescale_d  = prescale_q;
        psc_cnt_d   = psc_cnt_q;
        auto_d      = auto_q;
        done_d      = 1'b0;

        if (i_abort) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            psc_cnt_d   = '0;
        end else if (i_start) begin
            ticks_d     = i_ticks;
            prescale_d  = i_prescale;
            auto_d      = i_auto_reload;
            remaining_d = i_ticks;
            psc_cnt_d   = '0;
            // A zero-length request expires immediately in either mode.
            if (i_ticks == '0) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (w_active && i_pause) begin
            state_d = ST_PAUSE;
        end else if (w_active) begin
            // Leaving PAUSE counts on the same edge so latency grows by exactly
            // the number of paused cycles.
            state_d = ST_RUN;
            if (w_tick) begin
                psc_cnt_d = '0;
                if (remaining_q == c_REM_ONE) begin
                    done_d = 1'b1;
                    if (auto_q) begin
                        remaining_d = ticks_q;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_EXPIRED;
                    end
                end else begin
                    remaining_d = remaining_q - c_REM_ONE;
                end
            end else begin
                psc_cnt_d = psc_cnt_q + c_PSC_ONE;
            end
        end
    end

    assign o_busy      = w_active;
    assign o_paused    = (state_q == ST_PAUSE);
    assign o_expired   = (state_q == ST_EXPIRED);
    assign o_done      = done_q;
    assign o_remaining = remaining_q;

endmodule

`default_nettype wire
